sub_result_stage: RTL and testbench

//  Registered output stage downstream of the 32-bit ripple subtractor. Captures diff/carryout/overflow

---
 rtl/sub_result_pkg.sv | 21 ++
 rtl/sub_result_flags.sv | 21 ++
 rtl/sub_result_stage.sv | 153 +++++++++++++++
 tb/tb_sub_result_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sub_result_pkg.sv
// Shared types and defaults for the subtractor result stage.
package sub_result_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CNT_W = 8;
    localparam logic [DEF_CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } state_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic slt;
        logic sltu;
    } flags_t;

endpackage

// File: rtl/sub_result_flags.sv
// Compare flags derived from a subtractor result (a - b).
module sub_result_flags
    import sub_result_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] diff_i,
    input  logic             carryout_i,
    input  logic             overflow_i,
    output flags_t           flags_o
);

    always_comb begin
        flags_o.zero = (diff_i == '0);
        flags_o.neg  = diff_i[WIDTH-1];
        flags_o.slt  = diff_i[WIDTH-1] ^ overflow_i;
        // carryout=1 means no borrow, i.e. a >= b unsigned
        flags_o.sltu = ~carryout_i;
    end

endmodule

// File: rtl/sub_result_stage.sv
// Registered, two-entry skid-buffered output stage for the ripple subtractor.
// Optional SUB_RESULT_STICKY_EN adds a sticky overflow flag with a clear input.
module sub_result_stage
    import sub_result_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SUB_RESULT_STICKY_EN
    input  logic             sticky_clr,
    output logic             sticky_ovf,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_diff,
    input  logic             in_carryout,
    input  logic             in_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_slt,
    output logic             out_sltu,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_diff_q, main_diff_d;
    logic [WIDTH-1:0]   skid_diff_q, skid_diff_d;
    flags_t             main_flags_q, main_flags_d;
    flags_t             skid_flags_q, skid_flags_d;
    flags_t             in_flags;
    logic               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]   ovf_count_q, ovf_count_d;
    logic               accept, pop;

    sub_result_flags #(
        .WIDTH (WIDTH)
    ) u_flags (
        .diff_i     (in_diff),
        .carryout_i (in_carryout),
        .overflow_i (in_overflow),
        .flags_o    (in_flags)
    );

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid & out_ready;

    always_comb begin
        state_d      = state_q;
        main_diff_d  = main_diff_q;
        main_flags_d = main_flags_q;
        skid_diff_d  = skid_diff_q;
        skid_flags_d = skid_flags_q;
        ovf_count_d  = ovf_count_q;

        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d      = StOne;
                    main_diff_d  = in_diff;
                    main_flags_d = in_flags;
                end
            end
            StOne: begin
                if (accept && !pop) begin
                    state_d      = StFull;
                    skid_diff_d  = in_diff;
                    skid_flags_d = in_flags;
                end else if (accept && pop) begin
                    main_diff_d  = in_diff;
                    main_flags_d = in_flags;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (pop) begin
                    state_d      = StOne;
                    main_diff_d  = skid_diff_q;
                    main_flags_d = skid_flags_q;
                end
            end
            default: state_d = StEmpty;
        endcase

        // Registered ready: deasserted only while both entries are occupied
        in_ready_d = (state_d != StFull);

        if (accept && in_overflow && (ovf_count_q != CntMax)) begin
            ovf_count_d = ovf_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StEmpty;
            main_diff_q  <= '0;
            main_flags_q <= '0;
            skid_diff_q  <= '0;
            skid_flags_q <= '0;
            in_ready_q   <= 1'b0;
            ovf_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            main_diff_q  <= main_diff_d;
            main_flags_q <= main_flags_d;
            skid_diff_q  <= skid_diff_d;
            skid_flags_q <= skid_flags_d;
            in_ready_q   <= in_ready_d;
            ovf_count_q  <= ovf_count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != StEmpty);
    assign out_diff  = main_diff_q;
    assign out_zero  = main_flags_q.zero;
    assign out_neg   = main_flags_q.neg;
    assign out_slt   = main_flags_q.slt;
    assign out_sltu  = main_flags_q.sltu;
    assign ovf_count = ovf_count_q;

`ifdef SUB_RESULT_STICKY_EN
    logic sticky_q, sticky_d;

    // Set has priority over a same-cycle clear
    always_comb begin
        sticky_d = sticky_q;
        if (accept && in_overflow) begin
            sticky_d = 1'b1;
        end else if (sticky_clr) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_ovf = sticky_q;
`endif

endmodule

// File: tb/tb_sub_result_stage.sv
// Directed self-checking bench for sub_result_stage: flag table, FIFO stall,
// counter saturation, reset while full and (when enabled) the sticky flag.
module tb_sub_result_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_diff = '0;
    logic        in_carryout = 1'b0;
    logic        in_overflow = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_diff;
    logic        out_zero, out_neg, out_slt, out_sltu;
    logic [7:0]  ovf_count;
`ifdef SUB_RESULT_STICKY_EN
    logic        sticky_clr = 1'b0;
    logic        sticky_ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int exp_ovf  = 0;

    sub_result_stage #(
        .WIDTH (32),
        .CNT_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef SUB_RESULT_STICKY_EN
        .sticky_clr  (sticky_clr),
        .sticky_ovf  (sticky_ovf),
`endif
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_diff     (in_diff),
        .in_carryout (in_carryout),
        .in_overflow (in_overflow),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_diff    (out_diff),
        .out_zero    (out_zero),
        .out_neg     (out_neg),
        .out_slt     (out_slt),
        .out_sltu    (out_sltu),
        .ovf_count   (ovf_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] diff;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
        logic        slt;
        logic        sltu;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic c, input logic o);
        @(negedge clk);
        in_valid    = v;
        in_diff     = d;
        in_carryout = c;
        in_overflow = o;
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'h7FFF_FFFB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h8000_0005, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        // Reset state and first-edge ready
        #12;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_ovf_count", {24'b0, ovf_count}, 32'd0);
        check("rst_out_diff", out_diff, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_pre_edge", {31'b0, in_ready}, 32'd0);
        tick();
        check("rel_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef SUB_RESULT_STICKY_EN
        check("rst_sticky", {31'b0, sticky_ovf}, 32'd0);
`endif

        // Flag table, one beat per vector with out_ready high
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].diff, vecs[i].cout, vecs[i].ovf);
            tick();
            if (vecs[i].ovf) exp_ovf++;
            check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("vec%0d_diff", i), out_diff, vecs[i].diff);
            check($sformatf("vec%0d_flags", i),
                  {28'b0, out_zero, out_neg, out_slt, out_sltu},
                  {28'b0, vecs[i].zero, vecs[i].neg, vecs[i].slt, vecs[i].sltu});
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        check("table_drain_valid", {31'b0, out_valid}, 32'd0);
        check("table_ovf_count", {24'b0, ovf_count}, exp_ovf);

        // FIFO ordering under backpressure
        out_ready = 1'b0;
        drive(1'b1, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h2, 1'b1, 1'b0);
        tick();
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        check("full_head_diff", out_diff, 32'h0);
        check("full_head_flags", {28'b0, out_zero, out_neg, out_slt, out_sltu}, 32'b1000);
        drive(1'b1, 32'h5, 1'b0, 1'b0);
        tick();
        check("stall_hold_diff", out_diff, 32'h0);
        check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        tick();
        check("pop1_diff", out_diff, 32'h2);
        check("pop1_valid", {31'b0, out_valid}, 32'd1);
        check("pop1_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check("pop2_diff", out_diff, 32'h5);
        check("pop2_sltu", {31'b0, out_sltu}, 32'd1);
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        check("fifo_drain_valid", {31'b0, out_valid}, 32'd0);

        // Saturating overflow counter
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 32'h7FFF_FFFB, 1'b1, 1'b1);
            tick();
            if (exp_ovf < 255) exp_ovf++;
            if (i == 0) begin
                check("ovf_beat_flags", {28'b0, out_zero, out_neg, out_slt, out_sltu}, 32'b0010);
            end
            if (i == 252) check("ovf_count_at_max", {24'b0, ovf_count}, 32'd255);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        check("ovf_count_sat", {24'b0, ovf_count}, exp_ovf);

        // Reset while FULL discards both buffered beats
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h22, 1'b1, 1'b0);
        tick();
        check("pre_rst_full", {31'b0, in_ready}, 32'd0);
        drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        check("midrst_out_diff", out_diff, 32'd0);
        check("midrst_ovf_count", {24'b0, ovf_count}, 32'd0);
        exp_ovf = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst_no_stale%0d", i), {31'b0, out_valid}, 32'd0);
        end

`ifdef SUB_RESULT_STICKY_EN
        drive(1'b1, 32'h7FFF_FFFB, 1'b1, 1'b1);
        tick();
        check("sticky_set", {31'b0, sticky_ovf}, 32'd1);
        drive(1'b1, 32'h7FFF_FFFB, 1'b1, 1'b1);
        sticky_clr = 1'b1;
        tick();
        check("sticky_set_wins", {31'b0, sticky_ovf}, 32'd1);
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        check("sticky_clr", {31'b0, sticky_ovf}, 32'd0);
        @(negedge clk);
        sticky_clr = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
